// File: rtl/ext_bus_pkg.sv
// Shared encodings for the external multiplexed-bus controller:
// FSM states, request size codes and the alignment rule.
package ext_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AHI,
        ALO,
        DATA,
        HOLD,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_t;

    function automatic logic misaligned(input size_t size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ext_bus_ctrl.sv
// Core-to-external bus bridge: multiplexed 16-bit address/data bus with
// split high/low address latches, wait states and byte-lane write strobes.
module ext_bus_ctrl
    import ext_bus_pkg::*;
#(
    parameter int unsigned HI_SKIP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  wait_cfg,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [15:0] bus_out,
    input  logic [15:0] bus_in,
    output logic        le_lo,
    output logic        le_hi,
    output logic        bus_dir,
    output logic        OEb,
    output logic        WEb_lo,
    output logic        WEb_hi
);

    state_t      state;
    state_t      state_nx;

    logic        we_q;
    size_t       size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  wait_q;
    logic [2:0]  cnt_q;
    logic        second_q;
    logic [15:0] first_q;
    logic [15:0] hi_tag_q;
    logic        hi_valid_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [15:0] h_in_hi;
    logic [31:0] h_q;
    logic        req_bad;
    logic        need_hi;
    logic        more;
    logic        lane_lo;
    logic        lane_hi;
    logic [15:0] wr_half;

    assign h_in_hi = {1'b0, req_addr[31:17]};
    assign h_q     = {1'b0, addr_q[31:1]};
    assign req_bad = misaligned(size_t'(req_size), req_addr[1:0]);
    assign need_hi = (HI_SKIP == 0) || !hi_valid_q || (h_in_hi != hi_tag_q);
    assign more    = (size_q == SZ_WORD) && !second_q;

    always_comb begin
        lane_lo = 1'b1;
        lane_hi = 1'b1;
        wr_half = wdata_q[15:0];
        case (size_q)
            SZ_BYTE: begin
                lane_lo = !addr_q[0];
                lane_hi = addr_q[0];
                wr_half = {wdata_q[7:0], wdata_q[7:0]};
            end
            SZ_WORD: wr_half = second_q ? wdata_q[31:16] : wdata_q[15:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = req_bad ? RESP : (need_hi ? AHI : ALO);
                end
            end
            AHI:  state_nx = ALO;
            ALO:  state_nx = DATA;
            DATA: begin
                if (cnt_q == '0) begin
                    state_nx = we_q ? HOLD : (more ? ALO : RESP);
                end
            end
            HOLD: state_nx = more ? ALO : RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus outputs decode straight from the state register so reset idles them at once.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        bus_out   = '0;
        le_lo     = 1'b0;
        le_hi     = 1'b0;
        bus_dir   = 1'b0;
        OEb       = 1'b1;
        WEb_lo    = 1'b1;
        WEb_hi    = 1'b1;
        case (state)
            AHI: begin
                bus_out = h_q[31:16];
                le_hi   = 1'b1;
                bus_dir = 1'b1;
            end
            ALO: begin
                // A word's H is even, so OR-ing in the second-half flag is H+1.
                bus_out = h_q[15:0] | {15'd0, second_q};
                le_lo   = 1'b1;
                bus_dir = 1'b1;
            end
            DATA: begin
                if (we_q) begin
                    bus_out = wr_half;
                    bus_dir = 1'b1;
                    WEb_lo  = !lane_lo;
                    WEb_hi  = !lane_hi;
                end else begin
                    OEb = 1'b0;
                end
            end
            HOLD: begin
                bus_out = wr_half;
                bus_dir = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_q     <= '0;
            cnt_q      <= '0;
            second_q   <= 1'b0;
            first_q    <= '0;
            hi_tag_q   <= '0;
            hi_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        size_q   <= size_t'(req_size);
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        wait_q   <= wait_cfg;
                        second_q <= 1'b0;
                        err_q    <= req_bad;
                        rdata_q  <= '0;
                    end
                end
                AHI: begin
                    hi_tag_q   <= h_q[31:16];
                    hi_valid_q <= 1'b1;
                end
                ALO: cnt_q <= wait_q;
                DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else if (!we_q) begin
                        if (more) begin
                            first_q  <= bus_in;
                            second_q <= 1'b1;
                        end else begin
                            case (size_q)
                                SZ_BYTE: rdata_q <= {24'd0, addr_q[0] ? bus_in[15:8] : bus_in[7:0]};
                                SZ_HALF: rdata_q <= {16'd0, bus_in};
                                default: rdata_q <= {bus_in, first_q};
                            endcase
                        end
                    end
                end
                HOLD: begin
                    if (more) begin
                        second_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_err   = err_q;
    assign rsp_rdata = rdata_q;

    a_no_oe_we: assert property (@(posedge clk) disable iff (!rst_n)
        !(!OEb && !(WEb_lo && WEb_hi)));
    a_no_le_strobe: assert property (@(posedge clk) disable iff (!rst_n)
        !((le_lo || le_hi) && !(OEb && WEb_lo && WEb_hi)));

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Directed bench for ext_bus_ctrl: two instances (HI_SKIP=1 and 0), each with
// an external address latch and a read memory whose contents are lo^hi^C3A5.
module tb_ext_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        req_valid0, req_valid1, req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  wait_cfg;

    logic        req_ready0, rsp_valid0, rsp_err0, le_lo0, le_hi0, bus_dir0, OEb0, WEb_lo0, WEb_hi0;
    logic [31:0] rsp_rdata0;
    logic [15:0] bus_out0, bus_in0;
    logic        req_ready1, rsp_valid1, rsp_err1, le_lo1, le_hi1, bus_dir1, OEb1, WEb_lo1, WEb_hi1;
    logic [31:0] rsp_rdata1;
    logic [15:0] bus_out1, bus_in1;

    ext_bus_ctrl #(.HI_SKIP(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .wait_cfg(wait_cfg), .rsp_valid(rsp_valid0), .rsp_err(rsp_err0), .rsp_rdata(rsp_rdata0),
        .bus_out(bus_out0), .bus_in(bus_in0), .le_lo(le_lo0), .le_hi(le_hi0), .bus_dir(bus_dir0),
        .OEb(OEb0), .WEb_lo(WEb_lo0), .WEb_hi(WEb_hi0)
    );

    ext_bus_ctrl #(.HI_SKIP(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .wait_cfg(wait_cfg), .rsp_valid(rsp_valid1), .rsp_err(rsp_err1), .rsp_rdata(rsp_rdata1),
        .bus_out(bus_out1), .bus_in(bus_in1), .le_lo(le_lo1), .le_hi(le_hi1), .bus_dir(bus_dir1),
        .OEb(OEb1), .WEb_lo(WEb_lo1), .WEb_hi(WEb_hi1)
    );

    logic [15:0] hi_lat0 = '0, lo_lat0 = '0, hi_lat1 = '0, lo_lat1 = '0;
    always @(posedge clk) begin
        if (le_hi0) hi_lat0 <= bus_out0;
        if (le_lo0) lo_lat0 <= bus_out0;
        if (le_hi1) hi_lat1 <= bus_out1;
        if (le_lo1) lo_lat1 <= bus_out1;
    end
    assign bus_in0 = lo_lat0 ^ hi_lat0 ^ 16'hC3A5;
    assign bus_in1 = lo_lat1 ^ hi_lat1 ^ 16'hC3A5;

    logic        sel = 1'b0;
    logic        m_ready, m_valid, m_err, m_le_lo, m_le_hi, m_dir, m_oeb, m_web_lo, m_web_hi;
    logic [31:0] m_rdata;
    logic [15:0] m_bus;
    always_comb begin
        if (sel) begin
            {m_ready, m_valid, m_err, m_le_lo, m_le_hi} = {req_ready1, rsp_valid1, rsp_err1, le_lo1, le_hi1};
            {m_dir, m_oeb, m_web_lo, m_web_hi}          = {bus_dir1, OEb1, WEb_lo1, WEb_hi1};
            m_rdata = rsp_rdata1;
            m_bus   = bus_out1;
        end else begin
            {m_ready, m_valid, m_err, m_le_lo, m_le_hi} = {req_ready0, rsp_valid0, rsp_err0, le_lo0, le_hi0};
            {m_dir, m_oeb, m_web_lo, m_web_hi}          = {bus_dir0, OEb0, WEb_lo0, WEb_hi0};
            m_rdata = rsp_rdata0;
            m_bus   = bus_out0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          cycles, n_le_hi, n_le_lo, n_oe, n_we_lo, n_we_hi, n_hold, n_viol;
    logic [15:0] alo0, alo1, wr_bus;
    logic        got_err;
    logic [31:0] got_rdata;

    task automatic do_req(input logic which, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] wc);
        logic        prev_we;
        logic [15:0] prev_bus;
        bit          done;
        @(negedge clk);
        sel       = which;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        wait_cfg  = wc;
        if (which) req_valid1 = 1'b1;
        else       req_valid0 = 1'b1;
        #1;
        check("ready_idle", m_ready, 1);
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the captured request must not change.
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        req_we     = ~we;
        req_size   = 2'd3;
        req_addr   = ~addr;
        req_wdata  = ~wdata;
        wait_cfg   = ~wc;
        {cycles, n_le_hi, n_le_lo, n_oe, n_we_lo, n_we_hi, n_hold} = '0;
        alo0 = '0; alo1 = '0; wr_bus = '0; got_err = 1'b0; got_rdata = '0;
        prev_we = 1'b0; prev_bus = '0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            cycles++;
            if (m_le_hi) n_le_hi++;
            if (m_le_lo) begin
                if (n_le_lo == 0) alo0 = m_bus;
                else              alo1 = m_bus;
                n_le_lo++;
            end
            if (!m_oeb)    n_oe++;
            if (!m_web_lo) n_we_lo++;
            if (!m_web_hi) n_we_hi++;
            if (!m_web_lo || !m_web_hi) wr_bus = m_bus;
            if (prev_we && m_web_lo && m_web_hi && m_dir && m_bus == prev_bus && !m_valid) n_hold++;
            if ((!m_oeb && (!m_web_lo || !m_web_hi)) ||
                ((m_le_lo || m_le_hi) && (!m_oeb || !m_web_lo || !m_web_hi))) n_viol++;
            prev_we  = !m_web_lo || !m_web_hi;
            prev_bus = m_bus;
            if (m_valid) begin
                done      = 1'b1;
                got_err   = m_err;
                got_rdata = m_rdata;
            end
        end
        check("rsp_seen", {31'd0, done}, 1);
        @(negedge clk);
        check("rsp_one_cycle", m_valid, 0);
    endtask

    initial begin
        bit done;
        int n_rsp;
        n_viol     = 0;
        rst_n      = 1'b1;
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_addr   = '0;
        req_wdata  = '0;
        wait_cfg   = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_bus_out", bus_out0, 16'h0000);
        check("rst_le", {le_hi0, le_lo0}, 0);
        check("rst_strobes", {OEb0, WEb_lo0, WEb_hi0}, 3'b111);
        check("rst_dir", bus_dir0, 0);
        check("rst_rsp", {rsp_valid0, rsp_err0}, 0);
        check("rst_rdata", rsp_rdata0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Word read 0x100, wait 0: AHI ALO DATA ALO DATA RESP
        do_req(0, 0, 2'd2, 32'h0000_0100, 32'h0, 3'd0);
        check("wr100_cycles", cycles, 6);
        check("wr100_le_hi", n_le_hi, 1);
        check("wr100_le_lo", n_le_lo, 2);
        check("wr100_alo0", alo0, 16'h0080);
        check("wr100_alo1", alo1, 16'h0081);
        check("wr100_oe", n_oe, 2);
        check("wr100_err", got_err, 0);
        check("wr100_rdata", got_rdata, 32'hC324_C325);

        // Byte write 0xA5 to 0x4000_0003, wait 2: high lane only, replicated data, HOLD
        do_req(0, 1, 2'd0, 32'h4000_0003, 32'h1234_56A5, 3'd2);
        check("bw_cycles", cycles, 7);
        check("bw_le_hi", n_le_hi, 1);
        check("bw_we_hi", n_we_hi, 3);
        check("bw_we_lo", n_we_lo, 0);
        check("bw_bus", wr_bus, 16'hA5A5);
        check("bw_hold", n_hold, 1);
        check("bw_alo", alo0, 16'h0001);
        check("bw_oe", n_oe, 0);

        // Back-to-back reads with HI_SKIP=1: second skips AHI
        do_req(0, 0, 2'd2, 32'h0000_0100, 32'h0, 3'd0);
        check("b2b0_first_le_hi", n_le_hi, 1);
        do_req(0, 0, 2'd2, 32'h0000_0104, 32'h0, 3'd0);
        check("b2b0_second_le_hi", n_le_hi, 0);
        check("b2b0_second_cycles", cycles, 5);
        check("b2b0_second_rdata", got_rdata, 32'hC326_C327);

        // Same pair with HI_SKIP=0: AHI every time
        do_req(1, 0, 2'd2, 32'h0000_0100, 32'h0, 3'd0);
        check("b2b1_first_le_hi", n_le_hi, 1);
        do_req(1, 0, 2'd2, 32'h0000_0104, 32'h0, 3'd0);
        check("b2b1_second_le_hi", n_le_hi, 1);
        check("b2b1_second_cycles", cycles, 6);
        check("b2b1_second_rdata", got_rdata, 32'hC326_C327);

        // Misaligned half read at 0x101
        do_req(0, 0, 2'd1, 32'h0000_0101, 32'h0, 3'd0);
        check("mis_cycles", cycles, 1);
        check("mis_err", got_err, 1);
        check("mis_rdata", got_rdata, 32'h0);
        check("mis_activity", n_le_hi + n_le_lo + n_oe + n_we_lo + n_we_hi, 0);

        // Illegal size 3
        do_req(0, 0, 2'd3, 32'h0000_0100, 32'h0, 3'd0);
        check("sz3_err", got_err, 1);
        check("sz3_cycles", cycles, 1);

        // Byte read at 0x103: high lane of 0xC324
        do_req(0, 0, 2'd0, 32'h0000_0103, 32'h0, 3'd0);
        check("br_cycles", cycles, 3);
        check("br_rdata", got_rdata, 32'h0000_00C3);
        check("br_err", got_err, 0);

        // Half write 0xBEEF at 0x202, wait 1
        do_req(0, 1, 2'd1, 32'h0000_0202, 32'hDEAD_BEEF, 3'd1);
        check("hw_cycles", cycles, 5);
        check("hw_alo", alo0, 16'h0101);
        check("hw_we", {n_we_lo[15:0], n_we_hi[15:0]}, {16'd2, 16'd2});
        check("hw_bus", wr_bus, 16'hBEEF);
        check("hw_hold", n_hold, 1);

        // Reset during a write DATA phase
        @(negedge clk);
        sel       = 1'b0;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h0000_0008;
        req_wdata = 32'h1111_2222;
        wait_cfg  = 3'd3;
        req_valid0 = 1'b1;
        @(posedge clk);
        #1 req_valid0 = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!WEb_lo0) done = 1'b1;
        end
        check("rst_mid_reach_data", {31'd0, done}, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_web", {WEb_lo0, WEb_hi0}, 2'b11);
        check("rst_mid_dir", bus_dir0, 0);
        n_rsp = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid0) n_rsp++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid0) n_rsp++;
        end
        check("rst_mid_no_rsp", n_rsp, 0);
        do_req(0, 0, 2'd2, 32'h0000_0100, 32'h0, 3'd0);
        check("post_rst_le_hi", n_le_hi, 1);
        check("post_rst_cycles", cycles, 6);
        check("post_rst_rdata", got_rdata, 32'hC324_C325);

        check("no_overlap", n_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_bus_ctrl.md
EXT_BUS_CTRL -- requirements
Module: ext_bus_ctrl

Interface
REQ-001 SHALL have parameter HI_SKIP, default 1: 1 omits the high-address latch phase when the upper address is unchanged.
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  core request.
REQ-005 SHALL have port req_ready  out  1  request accepted when valid&ready.
REQ-006 SHALL have port req_we  in  1  1=write.
REQ-007 SHALL have port req_size  in  2  0=byte, 1=half, 2=word; 3 is illegal.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  write data, LSB-aligned.
REQ-010 SHALL have port wait_cfg  in  3  extra wait cycles per data phase.
REQ-011 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_err  out  1  misaligned or illegal request; qualified by rsp_valid.
REQ-013 SHALL have port rsp_rdata  out  32  read data, zero-extended; qualified by rsp_valid.
REQ-014 SHALL have ports bus_out out 16 and bus_in in 16; multiplexed address/data bus.
REQ-015 SHALL have ports le_lo, le_hi  out  1 each  address-latch enables for H[15:0] and H[31:16].
REQ-016 SHALL have port bus_dir  out  1  1=controller drives bus.
REQ-017 SHALL have ports OEb, WEb_lo, WEb_hi  out  1 each  active-low read strobe and byte-lane write strobes.

Function
REQ-018 SHALL use states IDLE, AHI, ALO, DATA, HOLD, RESP; req_ready=1 only in IDLE.
REQ-019 SHALL capture req_* and wait_cfg on acceptance; later input changes have no effect.
REQ-020 SHALL flag misalignment (half with addr[0]=1, word with addr[1:0]!=0, or size 3) by going IDLE->RESP with rsp_err=1, rsp_rdata=0, and no strobe activity.
REQ-021 SHALL form halfword address H = {1'b0, addr[31:1]}.
REQ-022 SHALL enter AHI when HI_SKIP=0, hi_valid=0, or H[31:16]!=hi_tag; otherwise enter ALO; AHI drives bus_out=H[31:16], le_hi=1, sets hi_tag and hi_valid.
REQ-023 SHALL, in ALO (one cycle), drive bus_out=H[15:0] (H+1 for a word's second half) with le_lo=1.
REQ-024 SHALL hold DATA for wait_cfg+1 cycles: OEb=0 for reads; for writes, drive lane strobes and bus_out with write data.
REQ-025 SHALL use lanes: byte at addr[0]=0 -> WEb_lo, data[7:0]; addr[0]=1 -> WEb_hi, data[15:8]; byte write data replicated on both lanes; half/word -> both strobes.
REQ-026 SHALL sample bus_in on the final DATA cycle; byte reads return the selected lane in [7:0]; a word returns {second,first} halves.
REQ-027 SHALL, after a write DATA phase, enter HOLD for one cycle with strobes high and bus_out/bus_dir unchanged.
REQ-028 SHALL handle a word as two transfers, the second at H+1 (ALO-DATA[-HOLD] repeated, never AHI, since alignment precludes carry).
REQ-029 SHALL pulse rsp_valid for exactly the one RESP cycle, then return to IDLE.
REQ-030 SHALL keep bus_dir=1 in AHI, ALO, write DATA, and HOLD; 0 otherwise.
REQ-031 SHALL keep idle outputs: bus_out=0, le_*=0, OEb=WEb_*=1, bus_dir=0.
REQ-032 SHALL never assert OEb and a WEb simultaneously, nor le_* together with any strobe.

Reset
REQ-033 SHALL, on rst_n=0, immediately force state IDLE, hi_valid=0, all outputs to REQ-031 values, rsp_valid=0, rsp_err=0, and rsp_rdata=0.
REQ-034 SHALL abort any in-flight transfer on reset mid-operation without producing a response.

Structure
REQ-035 SHALL place the state enum and req_size encodings in shared package ext_bus_pkg.
REQ-036 SHALL be a single flat module; no sub-module is warranted.

Verification
REQ-037 SHALL cover a word read at 0x0000_0100 with wait_cfg=0 after reset: AHI, ALO(0x0080), DATA, ALO(0x0081), DATA, RESP; rsp_rdata={mem[0x81],mem[0x80]}; 6 cycles.
REQ-038 SHALL cover a byte write 0xA5 to 0x4000_0003 with wait_cfg=2: only WEb_hi low for 3 cycles; bus_out=0xA5A5; HOLD follows.
REQ-039 SHALL cover back-to-back reads at 0x100 then 0x104 with HI_SKIP=1: the second request shows no le_hi pulse; with HI_SKIP=0 it does.
REQ-040 SHALL cover a half read at 0x0000_0101: rsp_valid one cycle after acceptance, rsp_err=1, no strobe or latch activity.
REQ-041 SHALL cover rst_n low during a write DATA phase: WEb_* high and bus_dir=0 at once; no rsp_valid; the next request performs AHI.
